stack_mem_port: RTL

STACK_MEM_PORT -- requirements
Module: stack_mem_port

---
 rtl/stack_pkg.sv | 15 +
 rtl/stack_mem_port_if.sv | 22 ++
 rtl/stack_sp_reg.sv | 48 ++++
 rtl/stack_mem_port.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared types and constants for the memory-backed stack port.
// The state enum, the word size and the default stack base live here.
package stack_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int          WORD_BYTES         = 4;
   localparam logic [31:0] STACK_BASE_DEFAULT = 32'h20008C78;

endpackage

// File: rtl/stack_mem_port_if.sv
// Single-request memory bus: request held until a one-cycle ack.
// The master drives the address/data; the memory returns rdata with ack.
interface stack_mem_port_if;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );

endinterface

// File: rtl/stack_sp_reg.sv
// Stack pointer register: points at the next free word, moves one word per
// completed access, and reports full/empty against the fixed stack window.
module stack_sp_reg
   import stack_pkg::*;
#(
   parameter logic [31:0] BASE  = STACK_BASE_DEFAULT,
   parameter int          DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   input  logic        dec,
   output logic [31:0] sp,
   output logic [31:0] sp_below,
   output logic        full,
   output logic        empty
);

   localparam logic [31:0] STEP  = 32'(WORD_BYTES);
   localparam logic [31:0] LIMIT = BASE + 32'(WORD_BYTES * DEPTH);

   logic [31:0] sp_reg;
   logic [31:0] sp_next;

   // The callers only request a move that the full/empty flags allow.
   always_comb begin
      sp_next = sp_reg;
      if (inc) begin
         sp_next = sp_reg + STEP;
      end else if (dec) begin
         sp_next = sp_reg - STEP;
      end
   end

   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         sp_reg <= BASE;
      end else begin
         sp_reg <= sp_next;
      end
   end

   assign sp       = sp_reg;
   assign sp_below = sp_reg - STEP;
   assign full     = (sp_reg == LIMIT);
   assign empty    = (sp_reg == BASE);

endmodule

// File: rtl/stack_mem_port.sv
// Push/pop stack held in external memory; one request at a time, state
// updated on the falling clock edge to line up with processor registers.
module stack_mem_port
   import stack_pkg::*;
#(
   parameter logic [31:0] BASE  = STACK_BASE_DEFAULT,
   parameter int          DEPTH = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic [31:0]             push_data,
   output logic                    busy,
   output logic                    done,
   output logic [31:0]             pop_data,
   output logic [1:0]              err,
   output logic [31:0]             sp,
   output logic                    full,
   output logic                    empty,
   stack_mem_port_if.master        bus
);

   state_t      state_reg;
   state_t      state_next;
   logic        sp_inc;
   logic        sp_dec;
   logic        start_wr;
   logic        start_rd;
   logic        set_ovf;
   logic        set_unf;
   logic [31:0] sp_below;

   logic        mem_req_reg;
   logic        mem_we_reg;
   logic [31:0] mem_addr_reg;
   logic [31:0] mem_wdata_reg;
   logic [31:0] pop_data_reg;
   logic [1:0]  err_reg;

   stack_sp_reg #(
      .BASE  (BASE),
      .DEPTH (DEPTH)
   ) u_sp (
      .clk      (clk),
      .rst      (rst),
      .inc      (sp_inc),
      .dec      (sp_dec),
      .sp       (sp),
      .sp_below (sp_below),
      .full     (full),
      .empty    (empty)
   );

   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Rejected requests (full/empty) still pass through DONE so the caller
   // always sees a done pulse; simultaneous push+pop is simply dropped.
   always_comb begin
      state_next = state_reg;
      sp_inc     = 1'b0;
      sp_dec     = 1'b0;
      start_wr   = 1'b0;
      start_rd   = 1'b0;
      set_ovf    = 1'b0;
      set_unf    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (push && !pop) begin
               if (full) begin
                  set_ovf    = 1'b1;
                  state_next = ST_DONE;
               end else begin
                  start_wr   = 1'b1;
                  state_next = ST_WRITE;
               end
            end else if (pop && !push) begin
               if (empty) begin
                  set_unf    = 1'b1;
                  state_next = ST_DONE;
               end else begin
                  start_rd   = 1'b1;
                  state_next = ST_READ;
               end
            end
         end
         ST_WRITE: begin
            if (bus.mem_ack) begin
               sp_inc     = 1'b1;
               state_next = ST_DONE;
            end
         end
         ST_READ: begin
            if (bus.mem_ack) begin
               sp_dec     = 1'b1;
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         mem_req_reg   <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         pop_data_reg  <= '0;
         err_reg       <= '0;
      end else begin
         if (start_wr) begin
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= 1'b1;
            mem_addr_reg  <= sp;
            mem_wdata_reg <= push_data;
         end else if (start_rd) begin
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= sp_below;
         end else if (sp_inc || sp_dec) begin
            mem_req_reg   <= 1'b0;
         end
         if (sp_dec) begin
            pop_data_reg <= bus.mem_rdata;
         end
         err_reg <= err_reg | {set_ovf, set_unf};
      end
   end

   assign busy          = (state_reg != ST_IDLE);
   assign done          = (state_reg == ST_DONE);
   assign pop_data      = pop_data_reg;
   assign err           = err_reg;
   assign bus.mem_req   = mem_req_reg;
   assign bus.mem_we    = mem_we_reg;
   assign bus.mem_addr  = mem_addr_reg;
   assign bus.mem_wdata = mem_wdata_reg;

endmodule
